fixed_to_fp_encoder: RTL and testbench

- Converts a signed two's-complement Q16.16 fixed-point word into an IEEE-754 single-precision word. It is the inverse of the FPU's float-to-fixed decoder.
- Iterative design: normalises by shifting one bit per cycle, then packs the result and applies optional rounding.
- Valid/ready handshake on both sides. Sits on the FPU's result write-back path to float registers.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_round_pack.sv | 63 ++++++
 rtl/fixed_to_fp_encoder.sv | 82 ++++++++
 tb/tb_fixed_to_fp_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and the fixed-to-float
// encoder state type. Also imported by the float-to-fixed decoder.
package fp_pkg;

   localparam int FP_BIAS  = 127;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } enc_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational pack stage. It takes a normalised magnitude (bit 31 set), a
// shift count and a sign, and builds the IEEE-754 single word.
// Build option: define FP_ENC_ROUND_NEAREST_EN for round-to-nearest-even.
// Without it the mantissa is truncated toward zero on magnitude.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic        sign,
   input  logic [4:0]  sc,
   input  logic [31:0] mag,
   output logic [31:0] fp
);

   // A shift count of zero means the leading one was already at bit 31.
   localparam int EXP_OFFSET = FP_BIAS + (31 - FRAC_BITS);

   logic [FP_EXP_W-1:0] exp_base;
   logic [FP_EXP_W-1:0] exp_fin;
   logic [FP_MAN_W-1:0] man_trunc;
   logic [FP_MAN_W-1:0] man_fin;

   assign exp_base  = FP_EXP_W'(EXP_OFFSET) - FP_EXP_W'(sc);
   assign man_trunc = mag[30:8];

`ifdef FP_ENC_ROUND_NEAREST_EN
   logic          guard;
   logic          sticky;
   logic          round_up;
   logic [FP_MAN_W:0] man_inc;
   logic          unused_bits;

   assign unused_bits = mag[31];

   // Round to nearest even; a mantissa carry-out bumps the exponent.
   always_comb begin
      guard    = mag[7];
      sticky   = |mag[6:0];
      round_up = guard & (sticky | man_trunc[0]);
      man_inc  = {1'b0, man_trunc} + (FP_MAN_W+1)'(round_up);
      man_fin  = man_inc[FP_MAN_W-1:0];
      exp_fin  = exp_base;
      if (man_inc[FP_MAN_W]) begin
         man_fin = '0;
         exp_fin = exp_base + FP_EXP_W'(1);
      end
   end
`else
   logic unused_bits;

   assign unused_bits = ^{mag[31], mag[7:0]};

   // Truncation: guard and sticky bits are simply dropped.
   always_comb begin
      man_fin = man_trunc;
      exp_fin = exp_base;
   end
`endif

   assign fp = {sign, exp_fin, man_fin};

endmodule

// File: rtl/fixed_to_fp_encoder.sv
// Signed Q(31-FRAC_BITS).FRAC_BITS to IEEE-754 single converter.
// Normalises one bit per cycle, then packs through fp_round_pack.
// Build option: FP_ENC_ROUND_NEAREST_EN selects round-to-nearest-even
// (otherwise truncation); see fp_round_pack.
module fixed_to_fp_encoder
   import fp_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fixed_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_out
);

   enc_state_t  state;
   logic        sign;
   logic [31:0] mag;
   logic [4:0]  sc;
   logic [31:0] abs_in;
   logic [31:0] pack_word;

   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   assign abs_in = fixed_in[31] ? (~fixed_in + 32'd1) : fixed_in;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   fp_round_pack #(
      .FRAC_BITS(FRAC_BITS)
   ) u_round_pack (
      .sign(sign),
      .sc  (sc),
      .mag (mag),
      .fp  (pack_word)
   );

   // Conversion FSM: accept, shift until bit 31 is set, pack, hold until drained.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sign   <= 1'b0;
         mag    <= '0;
         sc     <= '0;
         fp_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign <= fixed_in[31];
                  mag  <= abs_in;
                  sc   <= '0;
                  if (fixed_in == '0) begin
                     fp_out <= '0;
                     state  <= DONE;
                  end else begin
                     state <= NORM;
                  end
               end
            end
            NORM: begin
               if (!mag[31]) begin
                  mag <= mag << 1;
                  sc  <= sc + 5'd1;
               end else begin
                  fp_out <= pack_word;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_to_fp_encoder.sv
// Self-checking bench for fixed_to_fp_encoder (Q16.16). The expected float
// is computed from the numeric value of the operand; honours
// FP_ENC_ROUND_NEAREST_EN like the design.
module tb_fixed_to_fp_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] fixed_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fp_out;

   int unsigned errors;
   int unsigned checks;

   fixed_to_fp_encoder #(
      .FRAC_BITS(16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .fixed_in (fixed_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .fp_out   (fp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: float of the signed Q16.16 value x.
   function automatic logic [31:0] ref_float(input logic [31:0] x);
      longint      v;
      longint      m;
      longint      man24;
      longint      rem;
      longint      half;
      int          p;
      int          e;
      int          sh;
      logic        s;
      logic [7:0]  ebits;
      logic [22:0] mbits;
      v = longint'($signed(x));
      if (v == 0) return 32'h0;
      s = (v < 0);
      m = s ? -v : v;
      p = 0;
      for (int i = 0; i < 63; i++) if (((m >> i) & 64'd1) != 0) p = i;
      e = p - 16;
      if (p > 23) begin
         sh    = p - 23;
         man24 = m >> sh;
         rem   = m & ((64'd1 << sh) - 1);
         half  = 64'd1 << (sh - 1);
`ifdef FP_ENC_ROUND_NEAREST_EN
         if (rem > half || (rem == half && (man24 % 2) == 1)) man24 = man24 + 1;
         if (man24 == (64'd1 << 24)) begin
            man24 = man24 >> 1;
            e     = e + 1;
         end
`else
         if (rem < 0 || half < 0) man24 = 0;
`endif
      end else begin
         man24 = m << (23 - p);
      end
      ebits = 8'(e + 127);
      mbits = 23'(man24);
      return {s, ebits, mbits};
   endfunction

   // Posedges after the accept edge until out_valid: 0 for zero, else 32-msb.
   function automatic int ref_latency(input logic [31:0] x);
      logic [31:0] m;
      int          p;
      if (x == 32'h0) return 0;
      m = x[31] ? (~x + 32'd1) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      return 32 - p;
   endfunction

   // Present an operand, wait for the result; leaves the block in DONE.
   task automatic start_and_wait(input logic [31:0] v, output logic [31:0] res,
                                 output int lat, output logic timed_out);
      int n;
      timed_out = 1'b0;
      @(negedge clk);
      fixed_in = v;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timed_out = 1'b1;
      lat = n;
      res = fp_out;
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic convert_check(input string name, input logic [31:0] v, input logic chk_lat);
      logic [31:0] res;
      logic [31:0] exp_res;
      int          lat;
      int          exp_lat;
      logic        to;
      start_and_wait(v, res, lat, to);
      exp_res = ref_float(v);
      exp_lat = ref_latency(v);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: out_valid never rose for operand %h", name, v);
      end else if (res !== exp_res) begin
         errors++;
         $display("FAIL %s value: operand %h got %h expected %h", name, v, res, exp_res);
      end
      if (chk_lat) begin
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: operand %h got %0d expected %0d", name, v, lat, exp_lat);
         end
      end
      drain();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      fixed_in  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || fp_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b fp_out=%h expected 1 0 00000000",
                  in_ready, out_valid, fp_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] vals [9];
      vals = '{32'h00010000, 32'hFFFF0000, 32'h80000000, 32'h00000000,
               32'h00000001, 32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h00018000};
      foreach (vals[i]) convert_check($sformatf("directed_%0d", i), vals[i], 1'b1);
   endtask

   task automatic test_known_constants();
      logic [31:0] res;
      int          lat;
      logic        to;
      logic [31:0] ops [4];
      logic [31:0] exps [4];
      ops  = '{32'h00010000, 32'hFFFF0000, 32'h80000000, 32'h00000001};
      exps = '{32'h3F800000, 32'hBF800000, 32'hC7000000, 32'h37800000};
      foreach (ops[i]) begin
         start_and_wait(ops[i], res, lat, to);
         checks++;
         if (to || res !== exps[i]) begin
            errors++;
            $display("FAIL const_%0d: operand %h got %h expected %h", i, ops[i], res, exps[i]);
         end
         drain();
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      for (int i = 0; i < 40; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
         convert_check($sformatf("random_%0d", i), v, 1'b1);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      logic [31:0] exp_res;
      int          lat;
      logic        to;
      exp_res = ref_float(32'h00030000);
      start_and_wait(32'h00030000, res, lat, to);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2) == 0;
         fixed_in = 32'h12345678;
         @(negedge clk);
         checks++;
         if (to || fp_out !== exp_res || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: fp_out=%h out_valid=%b in_ready=%b expected %h 1 0",
                     i, fp_out, out_valid, in_ready, exp_res);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || fp_out !== exp_res) begin
         errors++;
         $display("FAIL drain: out_valid=%b in_ready=%b fp_out=%h expected 0 1 %h",
                  out_valid, in_ready, fp_out, exp_res);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      fixed_in = 32'h00000001;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || fp_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: out_valid=%b in_ready=%b fp_out=%h expected 0 1 00000000",
                  out_valid, in_ready, fp_out);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) break;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: out_valid=%b expected 0", out_valid);
      end
      convert_check("after_reset", 32'hFFFE8000, 1'b1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_known_constants();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
